// File: rtl/video_timing_gen.sv
// 640x480@60 raster timing generator: registered counters, DE, syncs and line/frame pulses.
// Optional colour-bar test pattern on R/G/B when VTG_PATTERN_EN is defined.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       pixclk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       VDE,
  output logic [1:0] CD,
  output logic       frame_start,
  output logic       line_start,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       vde_q, vde_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_q, frame_d;
  logic       line_q, line_d;

  // Outputs are decoded from the next position so they line up with the registered counters.
  always_comb begin
    hcount_d = (hcount_q == H_MAX) ? '0 : hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_MAX) begin
      vcount_d = (vcount_q == V_MAX) ? '0 : vcount_q + 10'd1;
    end
    vde_d   = (hcount_d < H_ACT) && (vcount_d < V_ACT);
    hsync_d = !((hcount_d >= HS_BEG) && (hcount_d <= HS_END));
    vsync_d = !((vcount_d >= VS_BEG) && (vcount_d <= VS_END));
    line_d  = (hcount_d == '0);
    frame_d = (hcount_d == '0) && (vcount_d == '0);
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q <= H_MAX;
      vcount_q <= V_MAX;
      vde_q    <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      frame_q  <= 1'b0;
      line_q   <= 1'b0;
    end else if (en) begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      vde_q    <= vde_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      frame_q  <= frame_d;
      line_q   <= line_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign VDE         = vde_q;
  assign CD          = {vsync_q, hsync_q};
  assign frame_start = frame_q;
  assign line_start  = line_q;

`ifdef VTG_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [2:0]  bar_d;
  logic [23:0] rgb_d, rgb_q;

  // Bar index only matters inside the active area, so truncation past H_ACTIVE is harmless.
  always_comb begin
    bar_d = 3'(hcount_d / BAR_W);
    rgb_d = 24'h000000;
    if (vde_d) begin
      case (bar_d)
        3'd0:    rgb_d = 24'hFFFFFF;
        3'd1:    rgb_d = 24'hFFFF00;
        3'd2:    rgb_d = 24'h00FFFF;
        3'd3:    rgb_d = 24'h00FF00;
        3'd4:    rgb_d = 24'hFF00FF;
        3'd5:    rgb_d = 24'hFF0000;
        3'd6:    rgb_d = 24'h0000FF;
        default: rgb_d = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
    end else if (en) begin
      rgb_q <= rgb_d;
    end
  end

  assign {R, G, B} = rgb_q;
`else
  assign R = 8'h00;
  assign G = 8'h00;
  assign B = 8'h00;
`endif

endmodule
